// File: rtl/mux4x1_rr_arbiter.sv
// Four-requester round-robin arbiter steering a shared DATA_W-bit 4:1 mux
// into a one-entry registered output stage with a valid/ready handshake.
module mux4x1_rr_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [3:0]        gnt,
  output logic [1:0]        select,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  input  logic              q_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        select_q, select_d;
  logic [DATA_W-1:0] q_q, q_d;

  logic [1:0]        winner;
  logic              found;
  logic [1:0]        idx;
  logic              load;
  logic [DATA_W-1:0] mux_out;

  // Search starts just after the last grant and wraps back to it last.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    mux_out = a;
    case (winner)
      2'd0:    mux_out = a;
      2'd1:    mux_out = b;
      2'd2:    mux_out = c;
      default: mux_out = d;
    endcase
  end

  assign load = ((state_q == IDLE) || ((state_q == FULL) && q_ready)) && (|req);

  // Reset gates gnt so nothing looks granted while the stage is held clear.
  assign gnt = (load && rst_n) ? (4'b0001 << winner) : 4'b0000;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    select_d = select_q;
    q_d      = q_q;
    if (load) begin
      state_d  = FULL;
      ptr_d    = winner;
      select_d = winner;
      q_d      = mux_out;
    end else if ((state_q == FULL) && q_ready) begin
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd3;
      select_q <= 2'd0;
      q_q      <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      select_q <= select_d;
      q_q      <= q_d;
    end
  end

  assign select  = select_q;
  assign q       = q_q;
  assign q_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// Directed, table-driven bench for mux4x1_rr_arbiter plus hand-written
// reset-in-FULL sequence.
module tb_mux4x1_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] a, b, c, d;
  logic [3:0] gnt;
  logic [1:0] select;
  logic [7:0] q;
  logic       q_valid;
  logic       q_ready;

  int assertCount;
  int failCount;

  typedef struct {
    logic [3:0] req;
    logic [7:0] a, b, c, d;
    logic       rdy;
    logic [3:0] expGnt;
    logic [7:0] expQ;
    logic [1:0] expSel;
    logic       expValid;
  } vec_t;

  vec_t vecs[19];

  mux4x1_rr_arbiter #(.DATA_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .gnt     (gnt),
    .select  (select),
    .q       (q),
    .q_valid (q_valid),
    .q_ready (q_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [3:0] r, logic [7:0] va, logic [7:0] vb,
                              logic [7:0] vc, logic [7:0] vd, logic rdy,
                              logic [3:0] g, logic [7:0] eq, logic [1:0] es,
                              logic ev);
    vec_t v;
    v.req = r; v.a = va; v.b = vb; v.c = vc; v.d = vd; v.rdy = rdy;
    v.expGnt = g; v.expQ = eq; v.expSel = es; v.expValid = ev;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req     = v.req;
    a       = v.a;
    b       = v.b;
    c       = v.c;
    d       = v.d;
    q_ready = v.rdy;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst_n   = 1'b0;
    req     = 4'b0000;
    a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
    q_ready = 1'b0;

    // Single request, backpressure, drain, then round-robin and skip/wrap.
    vecs[0]  = mk(4'b0100, 8'h11, 8'h22, 8'h3C, 8'h44, 1'b0, 4'b0100, 8'h3C, 2'd2, 1'b1);
    vecs[1]  = mk(4'b0000, 8'h11, 8'h22, 8'h3C, 8'h44, 1'b0, 4'b0000, 8'h3C, 2'd2, 1'b1);
    vecs[2]  = mk(4'b1000, 8'h11, 8'h22, 8'h33, 8'hD4, 1'b0, 4'b0000, 8'h3C, 2'd2, 1'b1);
    vecs[3]  = mk(4'b1000, 8'h11, 8'h22, 8'h33, 8'hD4, 1'b0, 4'b0000, 8'h3C, 2'd2, 1'b1);
    vecs[4]  = mk(4'b1000, 8'h11, 8'h22, 8'h33, 8'hD4, 1'b0, 4'b0000, 8'h3C, 2'd2, 1'b1);
    vecs[5]  = mk(4'b1000, 8'h11, 8'h22, 8'h33, 8'hD4, 1'b0, 4'b0000, 8'h3C, 2'd2, 1'b1);
    vecs[6]  = mk(4'b1000, 8'h11, 8'h22, 8'h33, 8'hD4, 1'b0, 4'b0000, 8'h3C, 2'd2, 1'b1);
    vecs[7]  = mk(4'b1000, 8'h11, 8'h22, 8'h33, 8'hD4, 1'b1, 4'b1000, 8'hD4, 2'd3, 1'b1);
    vecs[8]  = mk(4'b0000, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0000, 8'hD4, 2'd3, 1'b0);
    vecs[9]  = mk(4'b0000, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0000, 8'hD4, 2'd3, 1'b0);
    vecs[10] = mk(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0001, 8'h11, 2'd0, 1'b1);
    vecs[11] = mk(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0010, 8'h22, 2'd1, 1'b1);
    vecs[12] = mk(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0100, 8'h33, 2'd2, 1'b1);
    vecs[13] = mk(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b1000, 8'h44, 2'd3, 1'b1);
    vecs[14] = mk(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0001, 8'h11, 2'd0, 1'b1);
    vecs[15] = mk(4'b0100, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0100, 8'h33, 2'd2, 1'b1);
    vecs[16] = mk(4'b0011, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0001, 8'h11, 2'd0, 1'b1);
    vecs[17] = mk(4'b0011, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0010, 8'h22, 2'd1, 1'b1);
    vecs[18] = mk(4'b0000, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 4'b0000, 8'h22, 2'd1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_q", 16'(q), 16'h0000);
    checkOutput("reset_select", 16'(select), 16'h0000);
    checkOutput("reset_q_valid", 16'(q_valid), 16'h0000);
    checkOutput("reset_gnt", 16'(gnt), 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_gnt", i), 16'(gnt), 16'(vecs[i].expGnt));
      checkOutput($sformatf("vec%0d_onehot", i), 16'($countones(gnt) <= 1), 16'h0001);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_q", i), 16'(q), 16'(vecs[i].expQ));
      checkOutput($sformatf("vec%0d_select", i), 16'(select), 16'(vecs[i].expSel));
      checkOutput($sformatf("vec%0d_q_valid", i), 16'(q_valid), 16'(vecs[i].expValid));
    end

    // Load AA into FULL, then reset mid-cycle while requests are pending.
    @(negedge clk);
    req = 4'b0001; a = 8'hAA; q_ready = 1'b0;
    #1;
    checkOutput("rst_seq_load_gnt", 16'(gnt), 16'h0001);
    @(posedge clk);
    #1;
    checkOutput("rst_seq_q_aa", 16'(q), 16'h00AA);
    checkOutput("rst_seq_valid_full", 16'(q_valid), 16'h0001);
    @(negedge clk);
    req = 4'b1111; a = 8'h11; q_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_q", 16'(q), 16'h0000);
    checkOutput("rst_async_select", 16'(select), 16'h0000);
    checkOutput("rst_async_q_valid", 16'(q_valid), 16'h0000);
    checkOutput("rst_async_gnt", 16'(gnt), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_release_gnt", 16'(gnt), 16'h0001);
    @(posedge clk);
    #1;
    checkOutput("rst_release_q", 16'(q), 16'h0011);
    checkOutput("rst_release_select", 16'(select), 16'h0000);
    checkOutput("rst_release_next_gnt", 16'(gnt), 16'h0002);
    @(posedge clk);
    #1;
    checkOutput("rst_release_q2", 16'(q), 16'h0022);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
